pc_stack_unit: RTL
==================

PC_STACK_UNIT -- requirements
Module: pc_stack_unit

Interface
REQ-001 Parameter ADDR_W, default 8: width of the program counter and of jump/return addresses.
REQ-002 Parameter STACK_DEPTH, default 4: number of return-address entries; legal values 2..16.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 pc_load  input  1  load pc from the selected source (decoder output).
REQ-006 pc_inc  input  1  increment pc (decoder output).
REQ-007 push  input  1  push return address onto the stack (JMS exec1).
REQ-008 pop  input  1  pop the stack (BBL exec1).
REQ-009 stack_mux  input  1  load source select: 0 = jump_addr, 1 = stack top.
REQ-010 jump_addr  input  ADDR_W  operand target address from program memory.
REQ-011 pc  output  ADDR_W  current program counter; drives the instruction-memory address.
REQ-012 sp  output  $clog2(STACK_DEPTH+1)  number of valid stack entries.
REQ-013 stack_full  output  1  high when sp == STACK_DEPTH.
REQ-014 stack_empty  output  1  high when sp == 0.
REQ-015 stack_err  output  1  sticky error flag for overflow, underflow or push/pop collision.

Function
REQ-016 pc, sp and stack_err SHALL be registered; stack_full and stack_empty SHALL be combinational decodes of sp.
REQ-017 Next-pc priority SHALL be: pc_load, then pc_inc, then hold. pc_load and pc_inc together (the JMP/JMS/BBL exec1 case) SHALL load and ignore the increment.
REQ-018 With pc_load=1 and stack_mux=0, pc SHALL become jump_addr on the next edge.
REQ-019 With pc_load=1 and stack_mux=1 and the stack non-empty, pc SHALL become the top entry on the next edge.
REQ-020 pc_inc alone SHALL add 1 modulo 2^ADDR_W; all-ones SHALL wrap to 0 with no flag.
REQ-021 push on a non-full stack SHALL write (pc + 1) mod 2^ADDR_W at index sp and increment sp, in the same edge as any pc update.
REQ-022 pop on a non-empty stack SHALL decrement sp. The popped value SHALL be the one used by a same-cycle pc_load with stack_mux=1.
REQ-023 Overflow: push when full SHALL leave the stack and sp unchanged and set stack_err; the pc update SHALL still occur.
REQ-024 Underflow: pop, or pc_load with stack_mux=1, on an empty stack SHALL leave sp unchanged and hold pc (no load, no increment), and SHALL set stack_err.
REQ-025 push and pop in the same cycle SHALL perform neither stack operation and SHALL set stack_err; the pc update SHALL follow REQ-017.
REQ-026 Stack storage SHALL need no reset; entries at index >= sp are don't-care.

Reset
REQ-027 rst_n=0 at an edge SHALL force pc=0, sp=0 and stack_err=0, overriding all other inputs including a mid-operation push or pop.
REQ-028 The first edge with rst_n=1 SHALL act on the inputs normally.

Configuration
REQ-029 Macro PC_STACK_ERR_EN: when defined, error detection and the sticky stack_err SHALL behave as in REQ-023..025.
REQ-030 Without PC_STACK_ERR_EN, stack_err SHALL be tied to 0. Overflow, underflow and collision SHALL still be suppressed as specified, silently.

Structure
REQ-031 ADDR_W default, STACK_DEPTH default and the sp-width constant SHALL live in the shared package cpu_pkg.
REQ-032 Storage and sp SHALL be a sub-module lifo_stack (push/pop/wdata/rdata/full/empty). pc_stack_unit SHALL hold the pc register, next-pc mux and error logic.

Verification
REQ-033 Reset then 5 cycles of pc_inc -> pc=5, sp=0, stack_empty=1, stack_err=0.
REQ-034 pc=0x10; pc_load+pc_inc+push, stack_mux=0, jump_addr=0x40 -> pc=0x40, sp=1, top=0x11; then pc_load+pop, stack_mux=1 -> pc=0x11, sp=0.
REQ-035 STACK_DEPTH=4; five JMS-style pushes -> after the 4th, stack_full=1; the 5th -> sp=4, stack_err=1, pc=jump_addr.
REQ-036 Empty stack; pc_load+pop, stack_mux=1, pc=0x22 -> pc=0x22, sp=0, stack_err=1 (0 when built without PC_STACK_ERR_EN).
REQ-037 pc=0xFF, pc_inc -> pc=0x00; push and pop together with sp=2 -> sp=2, stack_err=1.
REQ-038 rst_n=0 in the same cycle as push with sp=3 -> next cycle pc=0, sp=0, stack_err=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU package: default sizes for the program-counter / return-stack
// block, plus the next-pc source encoding used by pc_stack_unit.
//   ADDR_W_DEFAULT      - program counter and jump/return address width
//   STACK_DEPTH_DEFAULT - number of return-address entries
//   SP_W_DEFAULT        - width of the stack pointer for the default depth
package cpu_pkg;

  localparam int unsigned ADDR_W_DEFAULT      = 8;
  localparam int unsigned STACK_DEPTH_DEFAULT = 4;
  localparam int unsigned SP_W_DEFAULT        = $clog2(STACK_DEPTH_DEFAULT + 1);

  // sp must be able to count 0..depth inclusive.
  function automatic int unsigned sp_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  typedef enum logic [1:0] {
    PcHold,
    PcInc,
    PcJump,
    PcRet
  } pc_sel_e;

endpackage

// File: rtl/lifo_stack.sv
// Return-address LIFO with an occupancy counter.
// Ports:
//   clk, rst_n    - clock, synchronous active-low reset (clears sp only)
//   push, pop     - stack operations; both together perform neither
//   wdata         - value written at index sp on an accepted push
//   rdata         - top entry (index sp-1); meaningless while empty
//   sp            - number of valid entries
//   full, empty   - combinational decodes of sp
// Push when full and pop when empty are silently ignored.
module lifo_stack
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = ADDR_W_DEFAULT,
  parameter int unsigned DEPTH = STACK_DEPTH_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   sp,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned SpW  = sp_width(DEPTH);
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [SpW-1:0]   sp_q, sp_d;
  logic             do_push, do_pop;
  logic [IdxW-1:0]  wr_idx, rd_idx;

  assign full    = (sp_q == SpW'(DEPTH));
  assign empty   = (sp_q == '0);
  assign do_push = push & ~pop & ~full;
  assign do_pop  = pop & ~push & ~empty;

  // An accepted push implies sp < DEPTH and an accepted pop implies sp > 0,
  // so both truncated indices stay inside the array when they are used.
  assign wr_idx = IdxW'(sp_q);
  assign rd_idx = IdxW'(sp_q - SpW'(1));

  always_comb begin
    sp_d = sp_q;
    if (do_push) begin
      sp_d = sp_q + SpW'(1);
    end else if (do_pop) begin
      sp_d = sp_q - SpW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Storage carries no reset; entries at or above sp are don't-care.
  always_ff @(posedge clk) begin
    if (rst_n && do_push) begin
      mem_q[wr_idx] <= wdata;
    end
  end

  assign rdata = mem_q[rd_idx];
  assign sp    = sp_q;

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with a return-address stack (JMS/BBL style subroutines).
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset
//   pc_load, pc_inc   - load beats increment; both together load
//   push, pop         - stack push (pc+1) / pop; both together do neither
//   stack_mux         - load source: 0 = jump_addr, 1 = stack top
//   jump_addr         - jump target
//   pc                - current program counter
//   sp                - number of valid stack entries
//   stack_full/empty  - decodes of sp
//   stack_err         - sticky overflow / underflow / collision flag
// Build option: define PC_STACK_ERR_EN to enable the sticky stack_err flag;
// otherwise stack_err is tied low and faulty operations are dropped silently.
module pc_stack_unit
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEFAULT,
  parameter int unsigned STACK_DEPTH = STACK_DEPTH_DEFAULT
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               pc_load,
  input  logic                               pc_inc,
  input  logic                               push,
  input  logic                               pop,
  input  logic                               stack_mux,
  input  logic [ADDR_W-1:0]                  jump_addr,
  output logic [ADDR_W-1:0]                  pc,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
  output logic                               stack_full,
  output logic                               stack_empty,
  output logic                               stack_err
);

  logic [ADDR_W-1:0] pc_q, pc_d, pc_plus1, top_addr;
  logic              underflow;
  pc_sel_e           pc_sel;

  assign pc_plus1 = pc_q + ADDR_W'(1);

  lifo_stack #(
    .WIDTH (ADDR_W),
    .DEPTH (STACK_DEPTH)
  ) u_lifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (pc_plus1),
    .rdata (top_addr),
    .sp    (sp),
    .full  (stack_full),
    .empty (stack_empty)
  );

  // Any attempt to consume the stack while it is empty freezes pc, even if
  // pc_inc is also asserted.
  assign underflow = stack_empty & (pop | (pc_load & stack_mux));

  always_comb begin
    pc_sel = PcHold;
    if (underflow) begin
      pc_sel = PcHold;
    end else if (pc_load) begin
      pc_sel = stack_mux ? PcRet : PcJump;
    end else if (pc_inc) begin
      pc_sel = PcInc;
    end
  end

  always_comb begin
    pc_d = pc_q;
    unique case (pc_sel)
      PcHold:  pc_d = pc_q;
      PcInc:   pc_d = pc_plus1;
      PcJump:  pc_d = jump_addr;
      PcRet:   pc_d = top_addr;
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

`ifdef PC_STACK_ERR_EN
  logic overflow, collision;
  logic err_q, err_d;

  assign overflow  = push & ~pop & stack_full;
  assign collision = push & pop;
  assign err_d     = err_q | overflow | underflow | collision;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign stack_err = err_q;
`else
  assign stack_err = 1'b0;
`endif

endmodule
